// File: rtl/mem_port_ctrl.sv
// Word-addressed RAM with an RD_LAT-deep read pipeline, a write port and a console FIFO at CON_ADDR.
// Defining MEM_WSTRB_EN adds the wr_strb byte-enable port.
module mem_port_ctrl #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 2048,
    parameter int                RD_LAT    = 1,
    parameter int                CON_DEPTH = 8,
    parameter logic [ADDR_W-1:0] CON_ADDR  = '1,
    parameter string             INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_resp_valid,
    output logic [DATA_W-1:0]   rd_resp_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef MEM_WSTRB_EN
    input  logic [DATA_W/8-1:0] wr_strb,
`endif
    output logic                con_valid,
    input  logic                con_ready,
    output logic [7:0]          con_data,
    output logic                oob_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = $clog2(CON_DEPTH);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [7:0]        r_con [CON_DEPTH];
    logic [CW:0]       r_wptr, r_rptr;
    logic              r_oob;
    logic [RD_LAT:1]   r_vld_pipe;
    logic [DATA_W-1:0] r_data_pipe [1:RD_LAT];

    logic [CW:0]       w_count;
    logic              w_full, w_empty;
    logic [NB-1:0]     w_strb;
    logic              w_rd_con, w_rd_oob, w_wr_con, w_wr_oob;
    logic              w_wr_acc, w_push, w_pop, w_ram_we;
    logic [DATA_W-1:0] w_rd_word;

`ifdef MEM_WSTRB_EN
    assign w_strb = wr_strb;
`else
    assign w_strb = '1;
`endif

    assign w_count  = r_wptr - r_rptr;
    assign w_full   = (w_count == (CW+1)'(CON_DEPTH));
    assign w_empty  = (r_wptr == r_rptr);

    assign w_rd_con = (rd_addr == CON_ADDR);
    assign w_rd_oob = !w_rd_con && ((rd_addr >> IDX_W) != '0);
    assign w_wr_con = (wr_addr == CON_ADDR);
    assign w_wr_oob = !w_wr_con && ((wr_addr >> IDX_W) != '0);

    // Full FIFO stalls the console write even if a pop happens this cycle.
    assign wr_ready = !(w_wr_con && w_full);
    assign w_wr_acc = wr_valid && wr_ready;
    assign w_push   = w_wr_acc && w_wr_con && w_strb[0];
    assign w_pop    = !w_empty && con_ready;
    assign w_ram_we = w_wr_acc && !w_wr_con && !w_wr_oob;

    always_comb begin
        w_rd_word = '0;
        if (w_rd_con)       w_rd_word = DATA_W'(w_count);
        else if (!w_rd_oob) w_rd_word = r_mem[rd_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (w_ram_we)
            for (int b = 0; b < NB; b++)
                if (w_strb[b]) r_mem[wr_addr[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_push) r_con[r_wptr[CW-1:0]] <= wr_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_oob      <= 1'b0;
            r_vld_pipe <= '0;
            for (int i = 1; i <= RD_LAT; i++) r_data_pipe[i] <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if ((rd_valid && w_rd_oob) || (w_wr_acc && w_wr_oob)) r_oob <= 1'b1;
            r_vld_pipe[1]  <= rd_valid;
            r_data_pipe[1] <= w_rd_word;
            for (int i = 2; i <= RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
        end
    end

    assign rd_ready      = 1'b1;
    assign rd_resp_valid = r_vld_pipe[RD_LAT];
    assign rd_resp_data  = r_data_pipe[RD_LAT];
    assign con_valid     = !w_empty;
    assign con_data      = w_empty ? 8'h00 : r_con[r_rptr[CW-1:0]];
    assign oob_err       = r_oob;
endmodule
